// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: row sense inputs, column strobes and key report outputs.
// The scanner uses master; the keypad/consumer side uses slave.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns, debounces whole-matrix snapshots and
// reports a single pressed key once per press via a one-cycle KEY_VALID pulse.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    keypad_scanner_if.master  kp
);

    localparam logic [15:0] DivLast   = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DebTarget = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {StIdle, StHeld, StRelease} state_t;

    logic [3:0]  row_meta_q, row_sync_q;
    logic [15:0] div_q;
    logic [1:0]  col_idx_q;
    logic [11:0] scan_q;        // columns 0..2; column 3 goes straight into the full scan
    logic [15:0] prev_scan_q;
    logic [3:0]  deb_cnt_q;
    state_t      state_q;
    logic [3:0]  key_code_q;
    logic        key_valid_q;
    logic        key_held_q;

    logic        sample;
    logic        scan_end;
    logic [15:0] full_scan;
    logic [3:0]  deb_cnt_d;
    logic        stable;
    logic        one_hot;
    logic [3:0]  key_idx;
    logic [15:0] held_mask;

    assign kp.col       = ~(4'b0001 << col_idx_q);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

    always_comb begin
        sample    = (div_q == DivLast);
        scan_end  = sample && (col_idx_q == 2'd3);
        full_scan = {~row_sync_q, scan_q};
        if (full_scan == prev_scan_q) begin
            deb_cnt_d = (deb_cnt_q >= DebTarget) ? DebTarget : deb_cnt_q + 4'd1;
        end else begin
            deb_cnt_d = 4'd1;
        end
        stable    = scan_end && (deb_cnt_d == DebTarget);
        one_hot   = (full_scan != 16'd0) && ((full_scan & (full_scan - 16'd1)) == 16'd0);
        key_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (full_scan[i]) begin
                key_idx = 4'(i);
            end
        end
        held_mask = 16'd1 << key_code_q;
    end

    // Row synchronizer; idle (pulled-up) value is all ones.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= kp.row;
            row_sync_q <= row_meta_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_q       <= 16'd0;
            col_idx_q   <= 2'd0;
            scan_q      <= 12'd0;
            prev_scan_q <= 16'd0;
            deb_cnt_q   <= 4'd0;
        end else begin
            if (sample) begin
                div_q     <= 16'd0;
                col_idx_q <= col_idx_q + 2'd1;
                case (col_idx_q)
                    2'd0:    scan_q[3:0]  <= ~row_sync_q;
                    2'd1:    scan_q[7:4]  <= ~row_sync_q;
                    2'd2:    scan_q[11:8] <= ~row_sync_q;
                    default: begin
                        prev_scan_q <= full_scan;
                        deb_cnt_q   <= deb_cnt_d;
                    end
                endcase
            end else begin
                div_q <= div_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (stable && one_hot) begin
                        key_code_q  <= key_idx;
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        state_q     <= StHeld;
                    end
                end
                StHeld: begin
                    if (scan_end && (full_scan != held_mask)) begin
                        key_held_q <= 1'b0;
                        state_q    <= StRelease;
                    end
                end
                StRelease: begin
                    // Only a clean all-released snapshot re-arms reporting.
                    if (stable && (full_scan == 16'd0)) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    key_held_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: behavioural keypad matrix plus a key-code scoreboard.
module tb_keypad_scanner;

    logic        CLK;
    logic        RST_N;
    logic [15:0] pressed;
    logic [3:0]  row_drv;
    logic [3:0]  sb[$];
    logic [3:0]  exp_code;
    logic        prev_valid;
    int          checks;
    int          errors;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .kp    (kp)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Matrix model: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        row_drv = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!kp.col[c]) begin
                row_drv = row_drv & ~pressed[c*4 +: 4];
            end
        end
    end
    assign kp.row = row_drv;

    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_valid <= 1'b0;
        end else begin
            if (kp.key_valid) begin
                checks++;
                if (prev_valid) begin
                    errors++;
                    $display("FAIL valid_width: KEY_VALID high 2 cycles, required 1");
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_report: got code %0d, required no report",
                             kp.key_code);
                end else begin
                    exp_code = sb.pop_front();
                    if (kp.key_code !== exp_code) begin
                        errors++;
                        $display("FAIL key_code: got %0d, required %0d", kp.key_code, exp_code);
                    end
                end
            end
            prev_valid <= kp.key_valid;
        end
    end

    task automatic wait_drain(input int budget, output int left);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge CLK);
        left = sb.size();
    endtask

    task automatic test_reset;
        int n;
        RST_N   = 1'b0;
        pressed = 16'h0200;
        #23;
        checks++;
        if (kp.col !== 4'b1110 || kp.key_valid !== 1'b0 || kp.key_held !== 1'b0 ||
            kp.key_code !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: col=%b valid=%b held=%b code=%0d, required 1110 0 0 0",
                     kp.col, kp.key_valid, kp.key_held, kp.key_code);
        end
        sb.push_back(4'd9);
        @(negedge CLK);
        RST_N = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge CLK);
            n++;
            if (kp.key_valid) break;
        end
        checks++;
        if (n !== 48) begin
            errors++;
            $display("FAIL reset_latency: report after %0d cycles, required 48", n);
        end
        checks++;
        if (kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL reset_held: got %b, required 1", kp.key_held);
        end
        pressed = 16'h0;
        repeat (100) @(negedge CLK);
        checks++;
        if (kp.key_held !== 1'b0 || kp.key_code !== 4'd9) begin
            errors++;
            $display("FAIL reset_release: held=%b code=%0d, required 0 9",
                     kp.key_held, kp.key_code);
        end
    endtask

    task automatic test_scan_sequence;
        logic [3:0] exp_col;
        pressed = 16'h0;
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 32; k++) begin
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (kp.col !== exp_col) begin
                errors++;
                $display("FAIL col_seq[%0d]: got %b, required %b", k, kp.col, exp_col);
            end
            @(negedge CLK);
        end
        repeat (64) @(negedge CLK);
        checks++;
        if (kp.key_held !== 1'b0 || kp.key_code !== 4'd0) begin
            errors++;
            $display("FAIL idle_outputs: held=%b code=%0d, required 0 0", kp.key_held, kp.key_code);
        end
    endtask

    task automatic test_single_key;
        int left;
        sb.push_back(4'd9);
        pressed = 16'h0200;
        wait_drain(100, left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL single_report: %0d reports pending, required 0", left);
        end
        repeat (20) @(negedge CLK);
        checks++;
        if (kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL single_held: got %b, required 1", kp.key_held);
        end
        pressed = 16'h0;
        repeat (100) @(negedge CLK);
        checks++;
        if (kp.key_held !== 1'b0 || kp.key_code !== 4'd9) begin
            errors++;
            $display("FAIL single_release: held=%b code=%0d, required 0 9",
                     kp.key_held, kp.key_code);
        end
    endtask

    task automatic test_bounce;
        int left;
        sb.push_back(4'd9);
        for (int i = 0; i < 8; i++) begin
            pressed = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            repeat (5) @(negedge CLK);
        end
        checks++;
        if (sb.size() !== 1) begin
            errors++;
            $display("FAIL bounce_quiet: pending %0d, required 1", sb.size());
        end
        pressed = 16'h0200;
        wait_drain(120, left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL bounce_report: %0d reports pending, required 0", left);
        end
        pressed = 16'h0;
        repeat (100) @(negedge CLK);
        checks++;
        if (kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL bounce_release: held=%b, required 0", kp.key_held);
        end
    endtask

    task automatic test_two_keys;
        int left;
        pressed = 16'h0021;
        repeat (100) @(negedge CLK);
        checks++;
        if (kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL two_keys_held: got %b, required 0", kp.key_held);
        end
        sb.push_back(4'd0);
        pressed = 16'h0001;
        wait_drain(100, left);
        checks++;
        if (left !== 0 || kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL two_keys_report: pending=%0d held=%b, required 0 1", left, kp.key_held);
        end
        pressed = 16'h0;
        repeat (100) @(negedge CLK);
    endtask

    task automatic test_key_change;
        int left;
        sb.push_back(4'd9);
        pressed = 16'h0200;
        wait_drain(100, left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL change_first: %0d reports pending, required 0", left);
        end
        pressed = 16'h0008;
        repeat (40) @(negedge CLK);
        checks++;
        if (kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL change_held: got %b, required 0", kp.key_held);
        end
        repeat (80) @(negedge CLK);
        pressed = 16'h0;
        repeat (100) @(negedge CLK);
        sb.push_back(4'd3);
        pressed = 16'h0008;
        wait_drain(100, left);
        checks++;
        if (left !== 0 || kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL change_second: pending=%0d held=%b, required 0 1", left, kp.key_held);
        end
        pressed = 16'h0;
        repeat (100) @(negedge CLK);
    endtask

    task automatic test_back_to_back;
        int         left;
        logic [3:0] codes[4];
        codes = '{4'd1, 4'd14, 4'd7, 4'd12};
        for (int k = 0; k < 4; k++) begin
            sb.push_back(codes[k]);
            pressed = 16'd1 << codes[k];
            wait_drain(100, left);
            checks++;
            if (left !== 0 || kp.key_held !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: pending=%0d held=%b, required 0 1", k, left, kp.key_held);
            end
            pressed = 16'h0;
            repeat (96) @(negedge CLK);
        end
    endtask

    task automatic test_async_reset;
        int left;
        int n;
        sb.push_back(4'd9);
        pressed = 16'h0200;
        wait_drain(100, left);
        repeat (7) @(negedge CLK);
        checks++;
        if (left !== 0 || kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: pending=%0d held=%b, required 0 1", left, kp.key_held);
        end
        #3;
        RST_N = 1'b0;
        #1;
        checks++;
        if (kp.col !== 4'b1110 || kp.key_valid !== 1'b0 || kp.key_held !== 1'b0 ||
            kp.key_code !== 4'd0) begin
            errors++;
            $display("FAIL areset_outputs: col=%b valid=%b held=%b code=%0d, required 1110 0 0 0",
                     kp.col, kp.key_valid, kp.key_held, kp.key_code);
        end
        repeat (2) @(negedge CLK);
        sb.push_back(4'd9);
        RST_N = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge CLK);
            n++;
            if (kp.key_valid) break;
        end
        checks++;
        if (n !== 48) begin
            errors++;
            $display("FAIL areset_latency: report after %0d cycles, required 48", n);
        end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (kp.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_midpulse: valid=%b, required 0", kp.key_valid);
        end
        @(negedge CLK);
        sb.push_back(4'd9);
        RST_N = 1'b1;
        wait_drain(100, left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL areset_rereport: %0d reports pending, required 0", left);
        end
        pressed = 16'h0;
        repeat (100) @(negedge CLK);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        prev_valid = 1'b0;
        RST_N      = 1'b0;
        pressed    = 16'h0;
        test_reset();
        test_scan_sequence();
        test_single_key();
        test_bounce();
        test_two_keys();
        test_key_change();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000: clock cycles each column is driven; legal range 4..65535.
REQ-002 The block SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive identical full scans required for a stable snapshot; legal range 2..15.
REQ-003 The block SHALL have port CLK, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port ROW, input, 4 bits: keypad rows, active-low (pulled up), asynchronous to CLK.
REQ-006 The block SHALL have port COL, output, 4 bits: column strobes, active-low one-hot.
REQ-007 The block SHALL have port KEY_CODE, output, 4 bits: code of the last reported key, equal to col*4 + row.
REQ-008 The block SHALL have port KEY_VALID, output, 1 bit: one-cycle pulse when a new key is reported.
REQ-009 The block SHALL have port KEY_HELD, output, 1 bit: high while the reported key remains stably pressed.

Function
REQ-010 ROW SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-011 A divider SHALL count 0..SCAN_DIV-1 and wrap; the column index (2 bits) SHALL advance 0->1->2->3->0 on each wrap.
REQ-012 COL SHALL drive column index c low and all other columns high: c=0 -> 4'b1110, c=3 -> 4'b0111.
REQ-013 Synchronized ROW SHALL be sampled only when the divider equals SCAN_DIV-1; inverted bits are stored into scan bits [c*4+3:c*4], where 1 means pressed.
REQ-014 When column 3 is sampled, the complete 16-bit scan SHALL be compared with the previous full scan.
REQ-015 If the scans are equal, a 4-bit debounce counter SHALL increment, saturating at DEBOUNCE_SCANS; otherwise it SHALL load 1.
REQ-016 The snapshot is "stable" in the scan-end cycle in which the counter reaches or holds DEBOUNCE_SCANS.
REQ-017 The FSM SHALL have state IDLE: on a stable snapshot with exactly one bit set, load KEY_CODE with that bit index, assert KEY_VALID next cycle, and go to HELD.
REQ-018 In IDLE, a stable snapshot of zero bits or of two or more bits SHALL produce no report and the FSM SHALL remain in IDLE.
REQ-019 The FSM SHALL have state HELD: KEY_HELD=1; on any scan end where the scan differs from the single held key, go to RELEASE and drop KEY_HELD.
REQ-020 The FSM SHALL have state RELEASE: return to IDLE only on a stable all-zero snapshot, so a key changed without release is never reported.
REQ-021 KEY_VALID SHALL be high for exactly one cycle per report; KEY_CODE SHALL hold its value until the next report.
REQ-022 The column scan SHALL run continuously in every FSM state.

Reset
REQ-023 While RST_N=0, regardless of CLK: COL=4'b1110, divider=0, column index=0, scan registers=0, debounce counter=0, synchronizer=4'b1111, FSM=IDLE, KEY_CODE=0, KEY_VALID=0, KEY_HELD=0.
REQ-024 Reset deassertion SHALL be followed by a full fresh debounce; a key pressed across reset SHALL be reported once, after DEBOUNCE_SCANS scans.
REQ-025 Reset mid-pulse SHALL clear KEY_VALID immediately.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3, scan period 16 cycles)
REQ-026 Release reset with no key -> COL sequence 1110,1101,1011,0111 at 4 cycles each, repeating; KEY_VALID never asserts.
REQ-027 Hold column 2 / row 1 (ROW=4'b1101 while COL=4'b1011) -> KEY_VALID pulses once with KEY_CODE=9 after the 3rd identical scan; KEY_HELD=1 until release.
REQ-028 Press key 9 with ROW toggling every 5 cycles for the first 40 cycles, then steady -> exactly one KEY_VALID, KEY_CODE=9, no report during the bounce.
REQ-029 Press keys 0 and 5 together -> no KEY_VALID; release key 5 only -> KEY_VALID with KEY_CODE=0 after 3 stable scans.
REQ-030 Hold key 9, then switch directly to key 3 without a gap -> KEY_HELD falls, no report for 3; release all, press 3 -> KEY_VALID with KEY_CODE=3.
REQ-031 Assert RST_N=0 mid-scan while KEY_HELD=1 -> all outputs take their reset values asynchronously; the held key is re-reported after 3 scans.
